// File: rtl/reg_dump_pkg.sv
// rtl/reg_dump_pkg.sv - shared states and constants for the register dump sequencer (REG_DUMP_FRAME_EN adds SYNC/CSUM)
package reg_dump_pkg;

  localparam int         BYTES_PER_REG = 4;
  localparam logic [7:0] SYNC_BYTE     = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HALT,
`ifdef REG_DUMP_FRAME_EN
    SYNC,
`endif
    ADDR,
    LATCH,
    SEND,
`ifdef REG_DUMP_FRAME_EN
    CSUM,
`endif
    DONE
  } state_t;

endpackage

// File: rtl/reg_dump_ctrl_if.sv
// rtl/reg_dump_ctrl_if.sv - byte stream towards the UART transmitter
interface reg_dump_ctrl_if #(
  parameter int BYTE_W = 8
);
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/reg_dump_ser.sv
// rtl/reg_dump_ser.sv - word-to-byte serializer, MSB first, with valid/ready hold
module reg_dump_ser
  import reg_dump_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              single_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              drop_i,
  output logic              byte_done_o,
  output logic              last_done_o,
  reg_dump_ctrl_if.master   tx
);

  localparam int               CNT_W    = $clog2(BYTES_PER_REG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_REG - 1);

  logic [DATA_W-1:0] shadow_q, shadow_d, shifted;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              single_q, single_d;
  logic              hs, last;

  assign hs          = valid_q & tx.tx_ready;
  // A single-byte load (sync/checksum) sits in the top byte and ends after one transfer.
  assign last        = single_q | (cnt_q == LAST_CNT);
  assign byte_done_o = hs;
  assign last_done_o = hs & last;
  assign shifted     = shadow_q << (BYTE_W * int'(cnt_q));
  assign tx.tx_data  = valid_q ? shifted[DATA_W-1 -: BYTE_W] : '0;
  assign tx.tx_valid = valid_q;

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    single_d = single_q;
    if (load_i) begin
      shadow_d = word_i;
      cnt_d    = '0;
      valid_d  = 1'b1;
      single_d = single_i;
    end else if (hs) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (last || drop_i) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      single_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      single_q <= single_d;
    end
  end

endmodule

// File: rtl/reg_dump_ctrl.sv
// rtl/reg_dump_ctrl.sv - halts the pipeline and streams the register file over UART (REG_DUMP_FRAME_EN: sync + checksum framing)
module reg_dump_ctrl
  import reg_dump_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int BYTE_W   = 8
) (
  input  logic              clk,
  input  logic              inicio,
  input  logic              dump_req,
  input  logic              cpu_halted,
  input  logic [ADDR_W-1:0] cpu_a1,
  output logic [ADDR_W-1:0] rf_a1,
  input  logic [DATA_W-1:0] rf_rd1,
  output logic              halt_req,
  reg_dump_ctrl_if.master   tx,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              req_q;
  logic              halt_q, halt_d;
  logic              pend_q, pend_d;
  logic              aborted_q, aborted_d;
  logic              trigger, stop_tx, abort_now;
  logic              ser_load, ser_single, ser_drop, ser_byte_done, ser_last_done;
  logic [DATA_W-1:0] ser_word;
`ifdef REG_DUMP_FRAME_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
`endif

  assign trigger  = dump_req & ~req_q;
  // Once the pipeline unfreezes mid-byte, the byte in flight still completes.
  assign stop_tx  = pend_q | ~cpu_halted;
  assign rf_a1    = (state_q == ADDR || state_q == LATCH) ? idx_q : cpu_a1;
  assign halt_req = halt_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign aborted  = aborted_q;

  reg_dump_ser #(.DATA_W(DATA_W), .BYTE_W(BYTE_W)) u_ser (
    .clk         (clk),
    .rst         (inicio),
    .load_i      (ser_load),
    .single_i    (ser_single),
    .word_i      (ser_word),
    .drop_i      (ser_drop),
    .byte_done_o (ser_byte_done),
    .last_done_o (ser_last_done),
    .tx          (tx)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    halt_d     = halt_q;
    pend_d     = pend_q;
    aborted_d  = 1'b0;
    abort_now  = 1'b0;
    ser_load   = 1'b0;
    ser_single = 1'b0;
    ser_word   = rf_rd1;
    ser_drop   = 1'b0;
`ifdef REG_DUMP_FRAME_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (trigger) begin
          state_d = WAIT_HALT;
          halt_d  = 1'b1;
        end
      end
      WAIT_HALT: begin
        if (cpu_halted) begin
          idx_d = '0;
`ifdef REG_DUMP_FRAME_EN
          csum_d     = '0;
          ser_load   = 1'b1;
          ser_single = 1'b1;
          ser_word   = {BYTE_W'(SYNC_BYTE), {(DATA_W-BYTE_W){1'b0}}};
          state_d    = SYNC;
`else
          state_d = ADDR;
`endif
        end
      end
`ifdef REG_DUMP_FRAME_EN
      SYNC: begin
        if (!cpu_halted) pend_d = 1'b1;
        if (ser_byte_done) begin
          if (stop_tx) abort_now = 1'b1;
          else         state_d   = ADDR;
        end
      end
`endif
      ADDR: begin
        if (!cpu_halted) abort_now = 1'b1;
        else             state_d   = LATCH;
      end
      LATCH: begin
        if (!cpu_halted) begin
          abort_now = 1'b1;
        end else begin
          ser_load = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (!cpu_halted) pend_d = 1'b1;
        if (ser_byte_done) begin
`ifdef REG_DUMP_FRAME_EN
          csum_d = csum_q ^ tx.tx_data;
`endif
          if (stop_tx) begin
            abort_now = 1'b1;
          end else if (ser_last_done) begin
            if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_FRAME_EN
              ser_load   = 1'b1;
              ser_single = 1'b1;
              ser_word   = {csum_d, {(DATA_W-BYTE_W){1'b0}}};
              state_d    = CSUM;
`else
              state_d = DONE;
`endif
            end else begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = ADDR;
            end
          end
        end
      end
`ifdef REG_DUMP_FRAME_EN
      CSUM: begin
        if (!cpu_halted) pend_d = 1'b1;
        if (ser_byte_done) begin
          if (stop_tx) abort_now = 1'b1;
          else         state_d   = DONE;
        end
      end
`endif
      DONE: begin
        halt_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_now) begin
      state_d   = IDLE;
      halt_d    = 1'b0;
      pend_d    = 1'b0;
      aborted_d = 1'b1;
      ser_drop  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge inicio) begin
    if (inicio) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      req_q     <= 1'b0;
      halt_q    <= 1'b0;
      pend_q    <= 1'b0;
      aborted_q <= 1'b0;
`ifdef REG_DUMP_FRAME_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      req_q     <= dump_req;
      halt_q    <= halt_d;
      pend_q    <= pend_d;
      aborted_q <= aborted_d;
`ifdef REG_DUMP_FRAME_EN
      csum_q    <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb/tb_reg_dump_ctrl.sv - randomized bench for reg_dump_ctrl against a byte-stream model
module tb_reg_dump_ctrl;

  localparam int N = 32;
`ifdef REG_DUMP_FRAME_EN
  localparam int FRAME = 1;
`else
  localparam int FRAME = 0;
`endif

  logic        clk = 1'b0;
  logic        inicio, dump_req, cpu_halted;
  logic [4:0]  cpu_a1, rf_a1;
  logic [31:0] rf_rd1;
  logic        halt_req, busy, done, aborted;
  logic [31:0] bank [N];
  logic [7:0]  exp_q [$];

  int checks = 0, fails = 0, cyc = 0;
  int n_rx, done_cnt, ab_cnt, t_last, hr_after;
  logic [7:0] first_b, last_b, prev_data;
  logic       prev_stall = 1'b0;

  reg_dump_ctrl_if #(.BYTE_W(8)) tx_if ();

  reg_dump_ctrl dut (
    .clk        (clk),
    .inicio     (inicio),
    .dump_req   (dump_req),
    .cpu_halted (cpu_halted),
    .cpu_a1     (cpu_a1),
    .rf_a1      (rf_a1),
    .rf_rd1     (rf_rd1),
    .halt_req   (halt_req),
    .tx         (tx_if),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rf_rd1 <= bank[rf_a1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Expected stream: every register MSB first, optionally framed by sync and XOR checksum.
  task automatic build_exp();
    logic [7:0] x, b;
    x = 8'h00;
    exp_q.delete();
    if (FRAME != 0) exp_q.push_back(8'hA5);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 4; j++) begin
        b = bank[i][31-8*j -: 8];
        exp_q.push_back(b);
        x ^= b;
      end
    if (FRAME != 0) exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (!inicio) begin
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        if (n_rx < exp_q.size()) begin
          chk("byte", 32'(tx_if.tx_data), 32'(exp_q[n_rx]));
        end else begin
          checks++;
          fails++;
          $display("FAIL extra_byte actual=%h expected=none", tx_if.tx_data);
        end
        if (n_rx == 0) first_b = tx_if.tx_data;
        last_b = tx_if.tx_data;
        if (n_rx == 4*N - 1 + FRAME) t_last = cyc;
        n_rx++;
      end
      if (prev_stall)
        chk("hold_stable", 32'({tx_if.tx_valid, tx_if.tx_data}), 32'({1'b1, prev_data}));
      prev_stall = tx_if.tx_valid & ~tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
      if (!busy) chk("rf_a1_passthru", 32'(rf_a1), 32'(cpu_a1));
      if (done) begin
        done_cnt++;
        chk("done_len", 32'(n_rx), 32'(exp_q.size()));
      end
      if (aborted) begin
        ab_cnt++;
        chk("abort_outs", 32'({halt_req, tx_if.tx_valid, busy}), 32'(0));
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic run_dump(input int pct, input int abort_at, input int hold, input int reset_at,
                          output int c0);
    int   post;
    logic ended;
    n_rx = 0; done_cnt = 0; ab_cnt = 0; t_last = -1; hr_after = 0; post = 0; ended = 1'b0; c0 = 0;
    @(posedge clk); #1;
    dump_req = 1'b1;
    for (int k = 1; k < 3000; k++) begin
      @(posedge clk); #1;
      dump_req    = (k < hold);
      tx_if.tx_ready = ($urandom_range(0, 99) < pct);
      if (k == 3) begin
        chk("halt_req_set", 32'(halt_req), 32'(1));
        cpu_halted = 1'b1;
        c0 = cyc;
      end
      if (pct == 100 && abort_at < 0 && reset_at < 0 && k > 3) begin
        if (cyc == c0 + 19 + FRAME) chk("rf_a1_addr_idx3", 32'(rf_a1), 32'(3));
        if (cyc == c0 + 21 + FRAME) chk("rf_a1_send_cpu", 32'(rf_a1), 32'(cpu_a1));
      end
      if (abort_at >= 0 && cpu_halted && n_rx == abort_at) begin
        cpu_halted     = 1'b0;
        tx_if.tx_ready = 1'b0;
      end
      if (reset_at >= 0 && n_rx >= reset_at) begin
        #3 inicio = 1'b1;
        #1 chk("async_reset_outs",
               32'({halt_req, tx_if.tx_valid, tx_if.tx_data, busy, done, aborted}), 32'(0));
        ended = 1'b1;
        break;
      end
      if (done_cnt > 0 || ab_cnt > 0) begin
        ended      = 1'b1;
        cpu_halted = 1'b0;
        if (done_cnt > 0 && halt_req) hr_after++;
        post++;
        if (post >= 3 && k > hold + 3) break;
      end
    end
    chk("dump_ended", 32'(ended), 32'(1));
    cpu_halted = 1'b0; dump_req = 1'b0; tx_if.tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 inicio = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c0;
    inicio = 1'b1; dump_req = 1'b0; cpu_halted = 1'b0; cpu_a1 = 5'd9; tx_if.tx_ready = 1'b0;
    n_rx = 0; done_cnt = 0; ab_cnt = 0;
    for (int i = 0; i < N; i++) bank[i] = 32'h1000_0000 + i;
    build_exp();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", 32'({halt_req, tx_if.tx_valid, tx_if.tx_data, busy, done, aborted}), 32'(0));
    chk("reset_rf_a1", 32'(rf_a1), 32'(9));
    inicio = 1'b0;
    chk("model_first_data", 32'(exp_q[FRAME]), 32'h10);
    chk("model_last_data", 32'(exp_q[4*N-1+FRAME]), 32'h1F);

    // Full dump, UART always ready
    run_dump(100, -1, 1, -1, c0);
    chk("t1_bytes", 32'(n_rx), 32'(4*N + 2*FRAME));
    chk("t1_done", 32'(done_cnt), 32'(1));
    chk("t1_aborted", 32'(ab_cnt), 32'(0));
    chk("t1_first_byte", 32'(first_b), (FRAME != 0) ? 32'hA5 : 32'h10);
    chk("t1_last_hs_cycle", 32'(t_last - c0), 32'(192 + FRAME));

    // Same stream under a 30% ready duty
    run_dump(30, -1, 1, -1, c0);
    chk("t2_bytes", 32'(n_rx), 32'(4*N + 2*FRAME));
    chk("t2_done", 32'(done_cnt), 32'(1));

    // Pipeline resumes during register 5 byte 1
    for (int i = 0; i < N; i++) bank[i] = $urandom;
    build_exp();
    run_dump(100, 21 + FRAME, 1, -1, c0);
    chk("t3_bytes", 32'(n_rx), 32'(22 + FRAME));
    chk("t3_aborted", 32'(ab_cnt), 32'(1));
    chk("t3_done", 32'(done_cnt), 32'(0));

    // Level held high does not retrigger; a fresh edge does
    run_dump(100, -1, 300, -1, c0);
    chk("t4_done", 32'(done_cnt), 32'(1));
    chk("t4_no_retrigger", 32'(hr_after), 32'(0));
    run_dump(60, -1, 1, -1, c0);
    chk("t5_done", 32'(done_cnt), 32'(1));
    chk("t5_bytes", 32'(n_rx), 32'(4*N + 2*FRAME));

    // Asynchronous reset in the middle of SEND
    run_dump(100, -1, 1, 10, c0);
    chk("t6_no_pulses", 32'({done_cnt[7:0], ab_cnt[7:0]}), 32'(0));
    chk("t6_idle_outs", 32'({halt_req, busy, tx_if.tx_valid}), 32'(0));

    // All-zero register file
    for (int i = 0; i < N; i++) bank[i] = 32'h0;
    build_exp();
    run_dump(50, -1, 1, -1, c0);
    chk("t7_bytes", 32'(n_rx), 32'(4*N + 2*FRAME));
    chk("t7_last_zero", 32'(last_b), 32'(0));
    chk("t7_first_byte", 32'(first_b), (FRAME != 0) ? 32'hA5 : 32'h00);
    chk("t7_done", 32'(done_cnt), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/reg_dump_ctrl.md
Name: reg_dump_ctrl

Overview:
- Debug sequencer for the 32x32 register file. On request it halts the pipeline and takes over register-file read port 1.
- Walks addresses 0..NUM_REGS-1 and streams each 32-bit value MSB-first as 4 bytes over a valid/ready byte interface to the UART transmitter.
- Sits between decode, the register file and the debug/UART unit.
- Outside a dump it passes the pipeline's read address straight through.

Parameters:
NUM_REGS, 32, registers dumped (addresses 0..NUM_REGS-1)
ADDR_W, 5, register address width
DATA_W, 32, register data width; must be 4*BYTE_W
BYTE_W, 8, output byte width

Ports:
clk  in  1  clock, all state on rising edge
inicio  in  1  reset, asynchronous, active-high
dump_req  in  1  dump request; rising edge triggers
cpu_halted  in  1  pipeline frozen, no register writes in flight
cpu_a1  in  ADDR_W  pipeline read address for port 1
rf_a1  out  ADDR_W  address to register file A1
rf_rd1  in  DATA_W  register file RD1 (registered, 1-cycle latency)
halt_req  out  1  stall request to pipeline
tx_data  out  BYTE_W  byte to UART
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART accepts byte
busy  out  1  dump in progress (state != IDLE)
done  out  1  1-cycle pulse, dump completed
aborted  out  1  1-cycle pulse, dump abandoned

Behaviour:
- Reset (inicio=1, async): state IDLE, idx=0, byte_cnt=0, shadow=0, tx_data=0, tx_valid=0, halt_req=0, done=0, aborted=0, edge detector cleared. Reset mid-dump abandons immediately with no pulse.
- rf_a1: combinational. It is idx in ADDR and LATCH, and cpu_a1 in every other state.
- dump_req edge detect: a registered copy is kept. A trigger is dump_req & ~dump_req_q. Triggers outside IDLE are ignored. A level held high through DONE does not retrigger.
- FSM:
  - IDLE: on trigger, go to WAIT_HALT and set halt_req=1.
  - WAIT_HALT: when cpu_halted=1, go to ADDR with idx=0. There is no timeout.
  - ADDR: drive rf_a1=idx. The register file latches bank[idx] at this edge. Go to LATCH.
  - LATCH: rf_rd1 is valid. Set shadow<=rf_rd1, byte_cnt<=0, go to SEND.
  - SEND: tx_valid=1. tx_data = shadow[DATA_W-1-8*byte_cnt -: 8], MSB first.
    - A byte transfers when tx_valid & tx_ready. byte_cnt then increments.
    - tx_data and tx_valid hold stable while tx_ready=0. tx_valid never drops before its handshake.
    - On the transfer of byte 3: if idx==NUM_REGS-1, go to DONE; else idx<=idx+1 and go to ADDR.
  - DONE: done=1 for 1 cycle, halt_req<=0, go to IDLE.
- Minimum cost per register: 2 cycles of read plus 4 handshake cycles. Best case is 6 cycles per register, 192 cycles for a full dump.
- Abort when cpu_halted falls while busy after WAIT_HALT:
  - In ADDR or LATCH: go to IDLE immediately.
  - In SEND: finish the current byte handshake, then go to IDLE.
  - In both cases aborted=1 for 1 cycle, halt_req<=0, tx_valid<=0.
- idx never wraps. The last register ends the dump.
- halt_req stays high from WAIT_HALT through DONE/abort.

Optional Feature:
- REG_DUMP_FRAME_EN defined:
  - A state before the first ADDR sends sync byte 0xA5 with the same handshake.
  - After the last data byte, a state sends a checksum byte equal to the XOR of all 4*NUM_REGS data bytes. The sync byte is excluded.
  - The frame is 130 bytes at default parameters.
  - Abort rules apply in both extra states.
- Undefined: raw 128-byte stream and no checksum register.

Decomposition:
- Package reg_dump_pkg holds:
  - state enum: IDLE, WAIT_HALT, (SYNC), ADDR, LATCH, SEND, (CSUM), DONE
  - BYTES_PER_REG=4
  - SYNC_BYTE=8'hA5
- Sub-module reg_dump_ser: a 32-to-8 serializer owning shadow, byte_cnt and the valid/ready handshake. It has load and last_byte_done signals.

Test Plan:
- Registers preloaded r[i]=32'h1000_0000+i, tx_ready=1, pulse dump_req, cpu_halted asserted 3 cycles later -> 128 bytes, first 10 00 00 00, last 10 00 00 1F. done pulses once. The final-byte handshake cycle is 192 cycles after leaving WAIT_HALT.
- tx_ready random 30% duty -> byte stream identical to the previous case; tx_data never changes while tx_valid=1 and tx_ready=0.
- cpu_halted dropped during register 5, byte 1 -> that byte completes, aborted pulses, done stays 0, halt_req=0 next cycle.
- cpu_a1=5'd9 while IDLE -> rf_a1=9. Same input during ADDR with idx=3 -> rf_a1=3.
- dump_req held high 300 cycles -> exactly one dump. A second rising edge after DONE -> second dump.
- inicio asserted mid-SEND -> all outputs 0 asynchronously, state IDLE. With REG_DUMP_FRAME_EN and all registers 0 -> stream A5, 128x 00, checksum 00.
